// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the 16-bit Fibonacci PRBS (taps 16,14,13,11).
// Optional macro PRBS_CHK_BITCNT_EN adds the bit_cnt output.
module prbs16_checker #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 32,
    parameter int WIN_LEN  = 64,
    parameter int LOSS_THR = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_cnt
`endif
);

    localparam int GR_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WE_W  = $clog2(LOSS_THR + 1);

    localparam logic [GR_W-1:0]  LOCK_LAST = GR_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [WE_W-1:0]  LOSS_V    = WE_W'(LOSS_THR);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [15:0]       sr;
    logic [4:0]        fill;
    logic [GR_W-1:0]   good_run;
    logic [WIN_W-1:0]  win_cnt;
    logic [WE_W-1:0]   win_err;

    logic              pred;
    logic              mismatch;
    logic [WE_W-1:0]   win_err_inc;
    logic              lost;

    always_comb begin
        pred        = sr[15] ^ sr[13] ^ sr[12] ^ sr[10];
        mismatch    = in_bit ^ pred;
        win_err_inc = win_err + WE_W'(mismatch);
        lost        = mismatch && (win_err_inc >= LOSS_V);
    end

    // The FSM state register is the lock indication itself.
    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            sr        <= '0;
            fill      <= '0;
            good_run  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
`ifdef PRBS_CHK_BITCNT_EN
            bit_cnt   <= '0;
`endif
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        sr <= {sr[14:0], in_bit};
                        if (fill != 5'd16) begin
                            fill <= fill + 5'd1;
                        end else if (!mismatch && (sr != '0)) begin
                            if (good_run == LOCK_LAST) begin
                                state    <= LOCKED;
                                good_run <= '0;
                                win_cnt  <= '0;
                                win_err  <= '0;
                            end else begin
                                good_run <= good_run + GR_W'(1);
                            end
                        end else begin
                            // An all-zero register predicts zero forever; never trust it.
                            good_run <= '0;
                        end
                    end
                    LOCKED: begin
                        sr        <= {sr[14:0], pred};
                        err_pulse <= mismatch;
                        if (mismatch && (err_cnt != '1))
                            err_cnt <= err_cnt + CNT_W'(1);
`ifdef PRBS_CHK_BITCNT_EN
                        if (bit_cnt != '1)
                            bit_cnt <= bit_cnt + 32'd1;
`endif
                        if (lost) begin
                            state    <= HUNT;
                            sr       <= '0;
                            fill     <= '0;
                            good_run <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_err_inc;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
            if (clr_cnt) begin
                err_cnt <= '0;
`ifdef PRBS_CHK_BITCNT_EN
                bit_cnt <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: directed link scenarios plus random traffic,
// checked every cycle against a bit-history reference model.
module tb_prbs16_checker;

    localparam int LOCK_CNT = 32;
    localparam int WIN_LEN  = 64;
    localparam int LOSS_THR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt4;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_cnt, bit_cnt4;
`endif

    prbs16_checker #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        , .bit_cnt(bit_cnt)
`endif
    );

    prbs16_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .clr_cnt(clr_cnt), .locked(locked4), .err_pulse(err_pulse4),
        .err_cnt(err_cnt4)
`ifdef PRBS_CHK_BITCNT_EN
        , .bit_cnt(bit_cnt4)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: history of the last 16 bits the checker trusts.
    bit          hist[$];
    bit          m_locked, m_pulse;
    int unsigned m_cnt, m_cnt4, m_bits;
    int          m_fill, m_good, m_win, m_werr;
    logic [15:0] gen = 16'hFFFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic gen_bit(output bit b);
        b   = gen[15] ^ gen[13] ^ gen[12] ^ gen[10];
        gen = {gen[14:0], b};
    endtask

    task automatic clear_hist();
        hist.delete();
        for (int i = 0; i < 16; i++) hist.push_back(1'b0);
    endtask

    task automatic model_reset();
        clear_hist();
        m_locked = 0; m_pulse = 0; m_cnt = 0; m_cnt4 = 0; m_bits = 0;
        m_fill = 0; m_good = 0; m_win = 0; m_werr = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr);
        bit p, allz, e;
        m_pulse = 0;
        if (v) begin
            // Bit n = bit(n-16) ^ bit(n-14) ^ bit(n-13) ^ bit(n-11); hist[0] is oldest.
            p = hist[0] ^ hist[2] ^ hist[3] ^ hist[5];
            allz = 1;
            for (int i = 0; i < 16; i++) if (hist[i]) allz = 0;
            if (!m_locked) begin
                void'(hist.pop_front());
                hist.push_back(b);
                if (m_fill < 16) m_fill++;
                else if (b == p && !allz) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin
                        m_locked = 1; m_good = 0; m_win = 0; m_werr = 0;
                    end
                end else m_good = 0;
            end else begin
                void'(hist.pop_front());
                hist.push_back(p);
                e = (b != p);
                m_pulse = e;
                if (m_bits != 32'hFFFF_FFFF) m_bits++;
                if (e) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                    m_werr++;
                end
                if (m_werr >= LOSS_THR) begin
                    m_locked = 0; m_fill = 0; m_good = 0; m_win = 0; m_werr = 0;
                    clear_hist();
                end else if (m_win == WIN_LEN - 1) begin
                    m_win = 0; m_werr = 0;
                end else m_win++;
            end
        end
        if (clr) begin
            m_cnt = 0; m_cnt4 = 0; m_bits = 0;
        end
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, "locked"},     locked,     m_locked);
        check({pfx, "err_pulse"},  err_pulse,  m_pulse);
        check({pfx, "err_cnt"},    err_cnt,    m_cnt);
        check({pfx, "locked4"},    locked4,    m_locked);
        check({pfx, "err_pulse4"}, err_pulse4, m_pulse);
        check({pfx, "err_cnt4"},   err_cnt4,   m_cnt4);
`ifdef PRBS_CHK_BITCNT_EN
        check({pfx, "bit_cnt"},    bit_cnt,    m_bits);
`endif
    endtask

    task automatic step(input bit v, input bit b, input bit clr);
        @(negedge clk);
        in_valid = v; in_bit = b; clr_cnt = clr;
        @(posedge clk);
        #1;
        model_step(v, b, clr);
        compare_all("cyc_");
    endtask

    task automatic send_gen();
        bit b;
        gen_bit(b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic send_err();
        bit b;
        gen_bit(b);
        step(1'b1, ~b, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
        #1;
        model_reset();
        compare_all("rst_");
        check("rst_locked_const", locked, 1'b0);
        check("rst_err_cnt_const", err_cnt, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int pulses, guard, nvalid;
        bit seen, b;

        // Clean stream from seed FFFF: lock after 16 fill + 32 matches.
        do_reset();
        repeat (47) send_gen();
        check("t1_not_locked_47", locked, 1'b0);
        send_gen();
        check("t1_locked_48", locked, 1'b1);
        pulses = 0;
        repeat (1000) begin send_gen(); pulses += int'(err_pulse); end
        check("t1_no_pulses", pulses, 0);
        check("t1_err_cnt", err_cnt, 16'd0);

        // Single line error.
        send_err();
        check("t2_pulse", err_pulse, 1'b1);
        check("t2_err_cnt", err_cnt, 16'd1);
        pulses = 0;
        repeat (100) begin send_gen(); pulses += int'(err_pulse); end
        check("t2_no_more", pulses, 0);
        check("t2_still_locked", locked, 1'b1);

        // Eight errors inside one window force loss of lock.
        step(1'b0, 1'b0, 1'b1);
        check("t3_clr", err_cnt, 16'd0);
        guard = 0;
        while (m_win != 0 && guard < 128) begin send_gen(); guard++; end
        check("t3_window_aligned", (guard < 128), 1'b1);
        for (int k = 0; k < 8; k++) begin
            send_err();
            if (k < 7) begin
                check("t3_hold_lock", locked, 1'b1);
                send_gen();
            end
        end
        check("t3_lost", locked, 1'b0);
        check("t3_err_cnt8", err_cnt, 16'd8);
        repeat (47) send_gen();
        check("t3_not_relocked_47", locked, 1'b0);
        send_gen();
        check("t3_relocked_48", locked, 1'b1);
        check("t3_err_cnt_kept", err_cnt, 16'd8);

        // All-zero stream never locks.
        do_reset();
        seen = 0;
        repeat (500) begin step(1'b1, 1'b0, 1'b0); seen |= locked; end
        check("t4_never_locked", seen, 1'b0);
        repeat (48) send_gen();
        check("t4_locks_on_real", locked, 1'b1);

        // Saturation of the 4-bit counter, then clear racing an error.
        step(1'b0, 1'b0, 1'b1);
        repeat (20) begin
            repeat (63) send_gen();
            send_err();
        end
        check("t5_locked", locked, 1'b1);
        check("t5_cnt4_sat", err_cnt4, 4'd15);
        check("t5_cnt16", err_cnt, 16'd20);
        gen_bit(b);
        step(1'b1, ~b, 1'b1);
        check("t5_clr_wins", err_cnt4, 4'd0);
        check("t5_clr_wins16", err_cnt, 16'd0);
        check("t5_pulse", err_pulse, 1'b1);

        // Gapped valid, then reset mid-stream and re-lock through gaps.
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 2 == 1) send_gen();
            else step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            pulses += int'(err_pulse);
        end
        check("t6_no_false_err", pulses, 0);
        check("t6_locked_gaps", locked, 1'b1);
        do_reset();
        nvalid = 0;
        for (int i = 0; i < 200 && nvalid < 48; i++) begin
            if (i % 2 == 1) begin
                send_gen();
                nvalid++;
                if (nvalid == 47) check("t6_not_locked_47", locked, 1'b0);
            end else step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("t6_relock_48", locked, 1'b1);

        // Random traffic: valid gaps, sparse errors, occasional clears.
        for (int i = 0; i < 3000; i++) begin
            bit v, flip, clr;
            v    = ($urandom_range(0, 3) != 0);
            flip = ($urandom_range(0, 40) == 0);
            clr  = ($urandom_range(0, 150) == 0);
            b = 1'b0;
            if (v) gen_bit(b);
            step(v, b ^ flip, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
